// File: rtl/qram_pkg.sv
// Shared types and constants for the quadport RAM read-side initiator.
package qram_pkg;

  localparam int unsigned QRAM_ADDR_W = 16;
  localparam int unsigned QRAM_DATA_W = 32;
  localparam int unsigned QRAM_BURST  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } reader_state_t;

  // Four-word mode only from a burst-aligned address with a full burst left.
  function automatic logic [2:0] burst_words(input logic [QRAM_ADDR_W-1:0] addr,
                                             input logic [QRAM_ADDR_W-1:0] remaining);
    return ((addr[1:0] == 2'b00) && (remaining >= 16'(QRAM_BURST))) ? 3'd4 : 3'd1;
  endfunction

endpackage

// File: rtl/qram_word_fifo.sv
// Word buffer accepting 0..4 pushes and at most one pop per cycle.
// Push lane 0 is written first, so lanes keep address order.
module qram_word_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned DataW = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [2:0]               push_cnt_i,
  input  logic [4*DataW-1:0]       push_data_i,
  input  logic                     pop_i,
  output logic [DataW-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Masked so the head reads zero whenever nothing is buffered.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage write: lanes below push_cnt_i land at consecutive slots.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < push_cnt_i) begin
        mem_q[wr_ptr_q + AW'(i)] <= push_data_i[i*DataW +: DataW];
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/quadram_block_reader.sv
// Block reader: issues credit-limited single/four-word reads to the quadport
// RAM controller and streams returned words out in address order.
module quadram_block_reader
  import qram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] base_addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        qram_ren_o,
  output logic        qram_wen_o,
  output logic        qram_four_o,
  output logic [31:0] qram_addr_o,
  input  logic [31:0] qram_dout_a_i,
  input  logic [31:0] qram_dout_b_i,
  input  logic [31:0] qram_dout_c_i,
  input  logic [31:0] qram_dout_d_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o
);

  reader_state_t                 state_q, state_d;
  logic [QRAM_ADDR_W-1:0]        cur_addr_q, cur_addr_d;
  logic [QRAM_ADDR_W-1:0]        remaining_q, remaining_d;
  // Words requested last cycle; their data is on qram_dout this cycle.
  logic [2:0]                    resp_k_q, resp_k_d;
  logic [2:0]                    k;
  logic [15:0]                   need;
  logic                          issue;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_empty;

  assign k     = burst_words(cur_addr_q, remaining_q);
  // Registered count plus in-flight words bounds what the FIFO must absorb.
  assign need  = 16'(fifo_count) + 16'(resp_k_q) + 16'(k);
  assign issue = (state_q == StIssue) && (need <= 16'(FIFO_DEPTH));

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign qram_ren_o  = issue;
  assign qram_wen_o  = 1'b0;
  assign qram_four_o = issue && (k == 3'd4);
  assign qram_addr_o = issue ? {16'h0000, cur_addr_q} : 32'h0;
  assign resp_k_d    = issue ? k : 3'd0;
  assign out_valid_o = !fifo_empty;

  // Next-state, address and remaining-word bookkeeping.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          cur_addr_d  = base_addr_i;
          remaining_d = len_i;
          state_d     = (len_i != 16'd0) ? StIssue : StDone;
        end
      end
      StIssue: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + 16'(k);
          remaining_d = remaining_q - 16'(k);
          if (remaining_d == 16'd0) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((resp_k_q == 3'd0) && fifo_empty) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset also drops any response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      resp_k_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      resp_k_q    <= resp_k_d;
    end
  end

  qram_word_fifo #(
    .Depth (FIFO_DEPTH),
    .DataW (QRAM_DATA_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_cnt_i  (resp_k_q),
    .push_data_i ({qram_dout_d_i, qram_dout_c_i, qram_dout_b_i, qram_dout_a_i}),
    .pop_i       (out_ready_i),
    .head_o      (out_data_o),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

endmodule
